// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the instruction fetch/prefetch unit.
package fetch_prefetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous FIFO with flush; the head is read straight out of the storage registers.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem[rd_ptr];

    // A flush voids any push or pop issued in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: sequential address generation, credit-limited memory requests, prefetch queue.
// Optional FETCH_PERF_CNT_EN adds stall and retire counters.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST,
    output logic [31:0] INST_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] STALL_CNT,
    output logic [31:0] RETIRE_CNT
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;
    logic          grant;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [63:0]   fifo_head;
    fetch_entry_t  head;
    logic [31:0]   redirect_target;

    assign redirect_target = REDIRECT_PC & INST_ALIGN_MASK;
    assign head            = fifo_head;

    // Queued plus in-flight entries may never exceed the queue depth.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign IMEM_REQ    = !RESET && !REDIRECT
                         && (outstanding < CW'(MAX_OUTSTANDING))
                         && (credit_used < (CW+1)'(DEPTH));
    assign IMEM_ADDR   = fetch_pc;
    assign grant       = IMEM_REQ && IMEM_GNT;

    always_comb begin
        out_next = outstanding;
        if (grant && !IMEM_RVALID)
            out_next = outstanding + 1'b1;
        else if (!grant && IMEM_RVALID)
            out_next = outstanding - 1'b1;
    end

    assign fifo_push = IMEM_RVALID && !RESET && !REDIRECT && (discard == '0)
                       && (!fifo_full || fifo_pop);
    assign fifo_pop  = INST_VALID && INST_READY && !REDIRECT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_next;
            if (REDIRECT) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                discard  <= out_next;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (IMEM_RVALID) begin
                    if (discard != '0)
                        discard <= discard - 1'b1;
                    else
                        resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (REDIRECT),
        .push      (fifo_push),
        .push_data ({resp_pc, IMEM_RDATA}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign INST_VALID = !RESET && !fifo_empty;
    assign INST       = INST_VALID ? head.instr : NOP_INSTR;
    assign INST_PC    = RESET ? RESET_PC : (fifo_empty ? resp_pc : head.pc);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CNT  <= '0;
            RETIRE_CNT <= '0;
        end else begin
            if (INST_READY && !INST_VALID)
                STALL_CNT <= STALL_CNT + 32'd1;
            if (fifo_pop)
                RETIRE_CNT <= RETIRE_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order variable-latency memory model plus an expected-instruction scoreboard.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST;
    logic [31:0] INST_PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] STALL_CNT;
    logic [31:0] RETIRE_CNT;
`endif

    always #5 CLK = ~CLK;

    fetch_prefetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .INST_VALID  (INST_VALID),
        .INST_READY  (INST_READY),
        .INST        (INST),
        .INST_PC     (INST_PC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .STALL_CNT   (STALL_CNT),
        .RETIRE_CNT  (RETIRE_CNT)
`endif
    );

    typedef struct { int unsigned rdy; logic [31:0] addr; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          pops = 0;
    logic [31:0] m_pc = RST_PC;
    logic        want_vld = 1'b0;
    logic        want_noreq = 1'b0;
    logic        want_hold = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        first_pending = 1'b0;
    logic [31:0] first_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_mem();
        if (pend.size() > 0 && pend[0].rdy <= cyc) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = mem_word(pend[0].addr);
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = '0;
        end
    endtask

    // Inputs are set at the falling edge; sample, clock, then update the models.
    task automatic step_cycle();
        logic        c_rst, c_redir, c_gr, c_rv;
        logic [31:0] c_rpc;
        exp_t        e;
        #1;
        c_rst   = RESET;
        c_redir = REDIRECT;
        c_rpc   = REDIRECT_PC;
        c_rv    = IMEM_RVALID;
        c_gr    = IMEM_REQ && IMEM_GNT;
        if (RESET) begin
            chk_vec("req_rst", IMEM_REQ, 0);
            chk_vec("vld_rst", INST_VALID, 0);
            chk_vec("inst_rst", INST, NOP);
            chk_vec("pc_rst", INST_PC, RST_PC);
        end else begin
            if (REDIRECT)
                chk_vec("req_redir", IMEM_REQ, 0);
            if (IMEM_REQ) begin
                chk_vec("addr", IMEM_ADDR, m_pc);
                chk_vec("credit", pend.size() < MAX_OUT, 1);
            end
            if (want_vld)
                chk_vec("stream_vld", INST_VALID, 1);
            if (want_noreq)
                chk_vec("req_full", IMEM_REQ, 0);
            if (want_hold) begin
                chk_vec("req_hold", IMEM_REQ, 1);
                chk_vec("addr_hold", IMEM_ADDR, hold_addr);
            end
            if (INST_VALID && INST_READY && !REDIRECT) begin
                if (sb.size() == 0) begin
                    chk_vec("unexpected", INST_VALID, 0);
                end else begin
                    e = sb.pop_front();
                    chk_vec("inst_pc", INST_PC, e.pc);
                    chk_vec("inst", INST, e.data);
                    pops++;
                    if (first_pending) begin
                        chk_vec("first_pc", INST_PC, first_pc);
                        first_pending = 1'b0;
                    end
                end
            end
        end
        @(posedge CLK);
        if (c_rst) begin
            pend.delete();
            sb.delete();
            m_pc = RST_PC;
            cyc  = 0;
        end else begin
            if (c_rv)
                void'(pend.pop_front());
            if (c_gr)
                pend.push_back('{rdy: cyc + lat, addr: IMEM_ADDR});
            if (c_redir) begin
                sb.delete();
                m_pc = c_rpc & 32'hFFFF_FFFC;
            end else if (c_gr) begin
                sb.push_back('{pc: m_pc, data: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            cyc++;
        end
        @(negedge CLK);
        drive_mem();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        REDIRECT    = 1'b1;
        REDIRECT_PC = pc;
        step_cycle();
        REDIRECT    = 1'b0;
    endtask

    task automatic drain();
        IMEM_GNT   = 1'b0;
        INST_READY = 1'b1;
        repeat (12) step_cycle();
        chk_vec("drained", sb.size(), 0);
        IMEM_GNT = 1'b1;
    endtask

    initial begin
        RESET = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0;
        IMEM_GNT = 1'b0; INST_READY = 1'b0;
        drive_mem();
        @(negedge CLK);
        repeat (3) step_cycle();

        // Streaming with a 1-cycle memory.
        RESET = 1'b0; IMEM_GNT = 1'b1; INST_READY = 1'b1; lat = 1;
        first_pending = 1'b1; first_pc = RST_PC;
        repeat (5) step_cycle();
        want_vld = 1'b1;
        repeat (10) step_cycle();
        want_vld = 1'b0;
        drain();

        // Consumer stall fills the queue and throttles requests.
        INST_READY = 1'b0;
        do_redirect(32'h0);
        for (int i = 0; i < 10; i++) begin
            want_noreq = (i >= 5);
            step_cycle();
        end
        want_noreq = 1'b0;
        INST_READY = 1'b1;
        first_pending = 1'b1; first_pc = 32'h0;
        repeat (8) step_cycle();
        drain();

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_redirect(32'h0);
        for (int i = 0; i < 10 && pend.size() < 2; i++) step_cycle();
        chk_vec("wait_pend", pend.size(), 2);
        do_redirect(32'h0000_0102);
        first_pending = 1'b1; first_pc = 32'h0000_0100;
        repeat (15) step_cycle();
        drain();

        // Redirect coincident with a response, then a second redirect.
        lat = 1;
        repeat (6) step_cycle();
        for (int i = 0; i < 10 && !IMEM_RVALID; i++) step_cycle();
        chk_vec("wait_rvalid", IMEM_RVALID, 1);
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_0300;
        step_cycle();
        REDIRECT_PC = 32'h0000_0200;
        step_cycle();
        REDIRECT = 1'b0;
        first_pending = 1'b1; first_pc = 32'h0000_0200;
        repeat (10) step_cycle();
        drain();

        // Grant withheld: address holds; fetch PC wraps past the top of memory.
        IMEM_GNT = 1'b0;
        do_redirect(32'hFFFF_FFFD);
        hold_addr = 32'hFFFF_FFFC; want_hold = 1'b1;
        repeat (5) step_cycle();
        want_hold = 1'b0;
        IMEM_GNT = 1'b1;
        first_pending = 1'b1; first_pc = 32'hFFFF_FFFC;
        repeat (10) step_cycle();
        drain();

`ifdef FETCH_PERF_CNT_EN
        RESET = 1'b1;
        repeat (2) step_cycle();
        RESET = 1'b0; IMEM_GNT = 1'b0; INST_READY = 1'b1;
        repeat (20) step_cycle();
        chk_vec("stall_cnt", STALL_CNT, 20);
        INST_READY = 1'b0; IMEM_GNT = 1'b1;
        repeat (6) step_cycle();
        pops = 0;
        INST_READY = 1'b1;
        for (int i = 0; i < 40 && pops < 8; i++) step_cycle();
        INST_READY = 1'b0;
        step_cycle();
        chk_vec("retire_cnt", RETIRE_CNT, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
